// File: rtl/fadd_issue_ctrl_if.sv
// Handshake and adder bus for fadd_issue_ctrl: producer side, adder operands/result, consumer side.
// master = environment (producer, adder, consumer); slave = the issue controller.
interface fadd_issue_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      add_x1;
  logic [31:0]      add_x2;
  logic [31:0]      add_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_x1, in_x2, in_sub, in_tag, add_y, out_ready,
    input  in_ready, add_x1, add_x2, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_x1, in_x2, in_sub, in_tag, add_y, out_ready,
    output in_ready, add_x1, add_x2, out_valid, out_y, out_tag
  );
endinterface

// File: rtl/fadd_issue_ctrl.sv
// Issue controller for the fixed-latency pipelined FP adder: valid/tag shift pipe plus a
// credit-protected result FIFO. Optional counters (stall_cnt, op_cnt) under FADD_ISSUE_STATS_EN.
module fadd_issue_ctrl #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rstn,
  fadd_issue_ctrl_if.slave  bus
`ifdef FADD_ISSUE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       op_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic               in_fire, wr_en, pop;
  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic [TAG_W-1:0]   tpipe_q [LATENCY];
  logic [TAG_W-1:0]   tpipe_d [LATENCY];
  logic [31:0]        mem_y_q   [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  int unsigned        inflight;

  assign bus.add_x1 = bus.in_x1;
  assign bus.add_x2 = {bus.in_x2[31] ^ bus.in_sub, bus.in_x2[30:0]};

  // Credit is computed from registered state only, so a same-cycle pop cannot raise in_ready.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(vpipe_q[i]);
    end
    bus.in_ready = (32'(occ_q) + inflight) < FIFO_DEPTH;
  end

  assign bus.out_valid = (occ_q != '0);
  assign bus.out_y     = bus.out_valid ? mem_y_q[rd_ptr_q]   : '0;
  assign bus.out_tag   = bus.out_valid ? mem_tag_q[rd_ptr_q] : '0;

  always_comb begin
    in_fire    = bus.in_valid & bus.in_ready;
    wr_en      = vpipe_q[LATENCY-1];
    pop        = bus.out_valid & bus.out_ready;
    vpipe_d    = vpipe_q;
    tpipe_d    = tpipe_q;
    vpipe_d[0] = in_fire;
    tpipe_d[0] = bus.in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      tpipe_d[i] = tpipe_q[i-1];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!wr_en && pop) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < LATENCY; i++) tpipe_q[i] <= '0;
    end else begin
      vpipe_q  <= vpipe_d;
      tpipe_q  <= tpipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; occ gates everything that reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_y_q[wr_ptr_q]   <= bus.add_y;
      mem_tag_q[wr_ptr_q] <= tpipe_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(pop && occ_q == '0));
      assert (!(wr_en && !pop && occ_q == CNT_W'(FIFO_DEPTH)));
    end
  end

`ifdef FADD_ISSUE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, op_cnt_q, op_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    op_cnt_d    = op_cnt_q;
    if (bus.in_valid && !bus.in_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (in_fire && op_cnt_q != '1) op_cnt_d = op_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign op_cnt    = op_cnt_q;
`endif

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Scoreboard bench for fadd_issue_ctrl with a behavioural FP adder stub and a queue-based model.
module tb_fadd_issue_ctrl;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;

  logic clk;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  fadd_issue_ctrl_if #(.TAG_W(TW)) bus ();

`ifdef FADD_ISSUE_STATS_EN
  logic [31:0] stall_cnt, op_cnt;
`endif

  fadd_issue_ctrl #(
    .LATENCY(LAT),
    .FIFO_DEPTH(DEPTH),
    .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
`ifdef FADD_ISSUE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .op_cnt(op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single <-> real conversions; denormals flush to zero, results truncate.
  function automatic real sp2r(input logic [31:0] b);
    int  e;
    real r;
    if (b[30:23] == 8'd0) return 0.0;
    e = {24'd0, b[30:23]};
    r = $itor({8'd0, 1'b1, b[22:0]}) * (2.0 ** (e - 150));
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = {21'd0, d[62:52]} - 896;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  // Reference: arithmetic meaning of the requested operation.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    return r2sp(sub ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
  endfunction

  // Adder stub: LAT-cycle pipe, never reset, like the real adder.
  logic [31:0] stub_q [LAT];
  always @(posedge clk) begin
    stub_q[0] <= fp_add(bus.add_x1, bus.add_x2);
    for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign bus.add_y = stub_q[LAT-1];

  typedef struct {
    logic [31:0]   y;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  exp_t q[$];
  int   issued = 0;
  int   popped = 0;
  int   m_stall = 0;
  int   m_ops = 0;

  // Issue side: an op is accepted while fewer than DEPTH ops were accepted but not yet popped.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (!rstn) begin
      issued  <= 0;
      m_stall <= 0;
      m_ops   <= 0;
    end else begin
      exp_rdy = (issued - popped) < DEPTH;
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
      if (bus.in_valid) begin
        if (exp_rdy) begin
          e.y   = fp_ref(bus.in_x1, bus.in_x2, bus.in_sub);
          e.tag = bus.in_tag;
          e.due = cyc + LAT + 1;
          q.push_back(e);
          issued <= issued + 1;
          m_ops  <= m_ops + 1;
        end else begin
          m_stall <= m_stall + 1;
        end
      end
    end
  end

  // Output monitor: head becomes visible at its due cycle and leaves on out_ready.
  always @(negedge clk) begin
    logic exp_ov;
    if (!rstn) begin
      q.delete();
      popped <= 0;
    end else begin
      exp_ov = (q.size() != 0) && (q[0].due <= cyc);
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_ov});
      if (exp_ov) begin
        chk("out_y", {32'd0, bus.out_y}, {32'd0, q[0].y});
        chk("out_tag", {60'd0, bus.out_tag}, {60'd0, q[0].tag});
        if (bus.out_ready) begin
          void'(q.pop_front());
          popped <= popped + 1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                       input logic sub, input logic [TW-1:0] tag, input logic ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_x1     = x1;
    bus.in_x2     = x2;
    bus.in_sub    = sub;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    if (v) begin
      #1;
      chk("add_x1", {32'd0, bus.add_x1}, {32'd0, x1});
      chk("add_x2", {32'd0, bus.add_x2}, {32'd0, sub ? {~x2[31], x2[30:0]} : x2});
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'd0, 32'd0, 1'b0, '0, ordy);
  endtask

  task automatic rnd_op(input logic v, input logic ordy);
    drive(v, $urandom, $urandom, 1'($urandom_range(0, 1)), TW'($urandom), ordy);
  endtask

  task automatic chk_stats();
`ifdef FADD_ISSUE_STATS_EN
    chk("stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
    chk("op_cnt", {32'd0, op_cnt}, 64'(m_ops));
`endif
  endtask

  initial begin
    int n;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x1     = '0;
    bus.in_x2     = '0;
    bus.in_sub    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_y", {32'd0, bus.out_y}, 64'd0);
    chk("rst_out_tag", {60'd0, bus.out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;

    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, TW'(3), 1'b1);
    repeat (5) idle(1'b1);
    drive(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, TW'(5), 1'b1);
    repeat (5) idle(1'b1);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), TW'(i), 1'b1);
    end
    repeat (6) idle(1'b1);

    // Backpressure: 4 accepted, then 6 stalled cycles, then a single pop.
    repeat (10) rnd_op(1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    chk_stats();
    repeat (8) idle(1'b1);

    // Reset with 2 results queued and 2 still in the adder.
    repeat (4) rnd_op(1'b1, 1'b0);
    idle(1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #3 rstn = 1'b1;
    repeat (5) idle(1'b1);

    repeat (400) rnd_op($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);

    n = 0;
    while (q.size() != 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results still expected, required 0", q.size());
    end
    idle(1'b1);
    chk_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fadd_issue_ctrl.md
Name: fadd_issue_ctrl

Overview:
- Requester-side controller for the fixed-latency, handshake-free pipelined FP adder (fadd_multi).
- Accepts operand pairs from a valid/ready producer and optionally negates x2 for subtraction. Drives the adder and tracks in-flight operations with a valid/tag shift pipe.
- Captures each adder result into a credit-protected result FIFO, so downstream backpressure never drops a result.

Parameters:
- LATENCY, 2: cycles from adder operand presentation to valid adder y; matches fadd_multi.
- FIFO_DEPTH, 4: result FIFO entries; power of 2, at least 2.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept
- in_x1  in  32  operand 1 (IEEE single)
- in_x2  in  32  operand 2 (IEEE single)
- in_sub  in  1  1 = compute x1 - x2
- in_tag  in  TAG_W  tag returned with result
- add_x1  out  32  to adder x1
- add_x2  out  32  to adder x2
- add_y  in  32  from adder y
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_y  out  32  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Issue fire: in_fire = in_valid & in_ready.
- Adder drive (combinational):
  - add_x1 = in_x1.
  - add_x2 = {in_x2[31]^in_sub, in_x2[30:0]}.
  - Driven every cycle regardless of in_valid. Ignored unless in_fire.
- Valid pipe: vpipe[0..LATENCY-1] and tpipe, shifted every cycle unconditionally.
  - vpipe[0] <= in_fire; tpipe[0] <= in_tag.
  - Stage LATENCY-1 is aligned with add_y.
- Result write: when vpipe[LATENCY-1]=1, write {add_y, tpipe[LATENCY-1]} into the FIFO at the end of that cycle. No stall is possible, because credit guarantees space.
- Credit:
  - inflight = popcount(vpipe); occ = FIFO count; both registered.
  - in_ready = (occ + inflight) < FIFO_DEPTH.
  - There is no combinational path from out_ready or in_valid to in_ready.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- Output:
  - out_valid = (occ != 0).
  - out_y and out_tag show the FIFO head.
  - Pop on out_valid & out_ready.
  - The head must stay stable while out_valid & !out_ready.
- Latency: in_fire in cycle t -> out_valid in cycle t+LATENCY+1 (3 by default) if the FIFO was empty. Results leave in strict issue order.
- Throughput: 1 op/cycle sustained while out_ready=1.
- FIFO counters:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - occ is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous write and pop: occ unchanged, both pointers advance.
  - Pop when empty, or write when full, is unreachable; assert in simulation.
- Reset values: vpipe=0, occ=0, pointers=0, in_ready=1, out_valid=0, out_y=0, out_tag=0.
- Reset mid-operation: in-flight ops and FIFO contents are discarded. The adder's internal registers are not reset by this block; its stale outputs are ignored because vpipe is cleared.
- Special values (NaN, Inf, denormal) pass through untouched. The adder's result is taken as-is.

Optional Feature:
- Macro: FADD_ISSUE_STATS_EN.
- When defined, the block adds:
  - output stall_cnt [31:0]: increments each cycle with in_valid & !in_ready.
  - output op_cnt [31:0]: increments on each in_fire.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, both ports and all counter logic are absent.

Test Plan:
- Single add: in_x1=0x3F800000, in_x2=0x40000000, in_sub=0, tag=3 at cycle 0 -> out_valid in cycle 3 with out_y=0x40400000, out_tag=3.
- Subtract: in_x1=0x40400000, in_x2=0x3F800000, in_sub=1 -> add_x2=0xBF800000 and out_y=0x40000000.
- Back-to-back: 8 ops on consecutive cycles with out_ready=1 and tags 0..7 -> 8 results on consecutive cycles from cycle 3, in order, in_ready constantly 1.
- Backpressure:
  - Setup: out_ready=0, in_valid=1 held.
  - Acceptance: exactly 4 ops accepted, then in_ready=0 while occ+inflight=4.
  - Release: raise out_ready for 1 cycle -> one pop. in_ready returns to 1 the following cycle, not the same one.
- Async reset mid-flight: assert rstn=0 between clock edges with 2 ops in flight and 2 queued -> out_valid=0 and in_ready=1 immediately. After release, no stale result appears within 5 cycles.
- Stats (FADD_ISSUE_STATS_EN defined): the backpressure scenario held 6 stalled cycles -> stall_cnt=6, op_cnt matches accepted ops.
